// File: rtl/median_stream_if.sv
// median_stream_if: groups the upstream, filter and downstream handshake signals.
// Ports (via modports):
//   master (the controller): drives in_ready, flt_pixel, flt_rdy, out_pixel, out_valid, out_last
//   slave  (the environment): drives in_pixel, in_valid, flt_ready, flt_median, out_ready
interface median_stream_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] in_pixel;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] flt_pixel;
  logic                  flt_rdy;
  logic                  flt_ready;
  logic [DATA_WIDTH-1:0] flt_median;
  logic [DATA_WIDTH-1:0] out_pixel;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  modport master (
    input  in_pixel, in_valid, flt_ready, flt_median, out_ready,
    output in_ready, flt_pixel, flt_rdy, out_pixel, out_valid, out_last
  );
  modport slave (
    output in_pixel, in_valid, flt_ready, flt_median, out_ready,
    input  in_ready, flt_pixel, flt_rdy, out_pixel, out_valid, out_last
  );
endinterface

// File: rtl/median_stream_ctrl.sv
// median_stream_ctrl: streams one IMG_W x IMG_H frame through a median filter, one pixel in flight.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            begin a frame (honoured in IDLE or ERR only)
//   busy, done, err  activity, one-cycle completion pulse, timeout flag
//   col, row         position of the pixel in flight
//   s                stream/filter handshakes (median_stream_if.master)
module median_stream_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
  median_stream_if.master          s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_EMIT, S_DONE, S_ERR} state_t;
  state_t state, nxt;
  logic [TW-1:0] tcnt;
  logic flt_ready_q;
  logic rise, at_end, col_end, go;
  // only a fresh rising edge of flt_ready completes a filter call
  assign rise    = s.flt_ready & ~flt_ready_q;
  assign col_end = col == CW'(IMG_W - 1);
  assign at_end  = col_end && row == RW'(IMG_H - 1);
  assign go      = start && (state == S_IDLE || state == S_ERR);
  assign s.in_ready  = state == S_FETCH;
  assign s.flt_rdy   = state == S_ISSUE;
  assign s.out_valid = state == S_EMIT;
  assign s.out_last  = state == S_EMIT && at_end;
  assign done = state == S_DONE;
  assign err  = state == S_ERR;
  assign busy = state inside {S_FETCH, S_ISSUE, S_WAIT, S_EMIT};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_ERR: nxt = start ? S_FETCH : state;
      S_FETCH:       nxt = s.in_valid ? S_ISSUE : S_FETCH;
      S_ISSUE:       nxt = S_WAIT;
      // counter reaches TIMEOUT-1 on the TIMEOUT-th WAIT cycle
      S_WAIT:        nxt = rise ? S_EMIT : tcnt == TW'(TIMEOUT - 1) ? S_ERR : S_WAIT;
      S_EMIT:        nxt = !s.out_ready ? S_EMIT : at_end ? S_DONE : S_FETCH;
      S_DONE:        nxt = S_IDLE;
      default:       nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flt_ready_q <= 1'b0;
      tcnt        <= '0;
      s.flt_pixel <= '0;
      s.out_pixel <= '0;
      col         <= '0;
      row         <= '0;
    end else begin
      flt_ready_q <= s.flt_ready;
      if (s.in_ready && s.in_valid) s.flt_pixel <= s.in_pixel;
      if (state == S_ISSUE) tcnt <= '0;
      else if (state == S_WAIT && !rise) tcnt <= tcnt + TW'(1);
      if (state == S_WAIT && rise) s.out_pixel <= s.flt_median;
      if (go || state == S_DONE) begin
        col <= '0;
        row <= '0;
      end else if (state == S_EMIT && s.out_ready && !at_end) begin
        col <= col_end ? '0 : col + CW'(1);
        row <= col_end ? row + RW'(1) : row;
      end
    end
endmodule

// File: doc/median_stream_ctrl.md
Name: median_stream_ctrl

Overview:
Sequencer that streams one raster frame of IMG_W x IMG_H grayscale pixels through the median_filter datapath.
- Input side: pulls pixels from an upstream valid/ready stream.
- Filter side: issues each pixel to the filter with a one-cycle rdy strobe and waits for the filter's ready rising edge.
- Output side: returns each median on a downstream valid/ready stream, flagging the last pixel.
- Tracks row/column position, signals frame completion, and guards against a hung filter with a timeout.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_W, 640, pixels per row
IMG_H, 480, rows per frame
TIMEOUT, 255, max WAIT cycles for a filter ready edge before error; must be >= 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin frame; honoured only in IDLE or ERR
busy  out  1  high in FETCH/ISSUE/WAIT/EMIT
done  out  1  one-cycle pulse after last output handshake
err  out  1  sticky timeout flag
in_pixel  in  DATA_WIDTH  upstream pixel
in_valid  in  1  upstream valid
in_ready  out  1  controller accepts pixel
flt_pixel  out  DATA_WIDTH  pixel to filter (new_pixel)
flt_rdy  out  1  one-cycle strobe: flt_pixel valid
flt_ready  in  1  filter result ready; rising edge meaningful
flt_median  in  DATA_WIDTH  filter result (median_out)
out_pixel  out  DATA_WIDTH  median to downstream
out_valid  out  1  downstream valid
out_ready  in  1  downstream ready
out_last  out  1  qualifies final pixel of frame
col  out  $clog2(IMG_W)  column of pixel in flight
row  out  $clog2(IMG_H)  row of pixel in flight

Behaviour:
Reset:
- rst low asynchronously forces state IDLE.
- All outputs, counters, the timeout counter and the flt_ready history register clear to 0.
- A reset during any state, including mid-WAIT or mid-EMIT, abandons the frame; no done pulse.

States and transitions:
- IDLE: in_ready=0. start -> FETCH, col=row=0, err=0.
- FETCH: in_ready=1. On in_valid&in_ready, register in_pixel into flt_pixel -> ISSUE.
- ISSUE: flt_rdy=1 for exactly this cycle; timeout counter cleared -> WAIT.
- WAIT:
  - flt_ready_q holds flt_ready delayed one cycle.
  - Acceptance condition: flt_ready & ~flt_ready_q.
  - On acceptance: register flt_median into out_pixel -> EMIT.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 with no edge -> ERR.
  - Net effect: ERR entered after TIMEOUT WAIT cycles.
- EMIT: out_valid=1; out_pixel, out_last, col and row held stable until the handshake.
  - out_last = (col==IMG_W-1)&&(row==IMG_H-1).
  - On out_ready: if last -> DONE; else advance col, wrapping to 0 and incrementing row at IMG_W-1 -> FETCH.
- DONE: done=1 for one cycle; col/row reset to 0 -> IDLE.
- ERR: err=1, busy=0, in_ready=0, flt_rdy=0. Exits only via start (-> FETCH, err cleared, counters zeroed) or reset.

Rules:
- start is ignored in FETCH/ISSUE/WAIT/EMIT/DONE.
- A flt_ready edge outside WAIT is ignored. flt_ready held high with no new edge never completes a WAIT.
- One pixel in flight; no pipelining across filter calls.
- Latency: input handshake -> flt_rdy is 1 cycle; flt_ready edge -> out_valid is 1 cycle.
- Minimum 4 cycles per pixel when the filter edge lands on the first WAIT cycle.

Test Plan:
- IMG_W=2, IMG_H=2; filter model raises flt_ready 3 cycles after each flt_rdy and returns pixel+1; inputs 10,20,30,40 -> outputs 11,21,31,41; out_last only on 41; col/row = (0,0),(1,0),(0,1),(1,1); done pulses once, one cycle after the 41 handshake.
- Hold out_ready low 5 cycles during EMIT -> out_pixel/out_valid/out_last stable, in_ready stays 0, flt_rdy stays 0; released -> next FETCH.
- TIMEOUT=8; filter never responds -> ERR after exactly 8 WAIT cycles, err=1, busy=0. start then clears err and restarts at col=row=0.
- Filter holds flt_ready high through ISSUE and into WAIT -> no acceptance. Drop then re-raise -> accepted on the rising edge.
- Assert start while in WAIT -> ignored, no state change. Drop rst low mid-WAIT -> all outputs 0 asynchronously, IDLE after release, no done.
